// File: rtl/ram_seq_ctrl_if.sv
// Bundle of the loader, byte-dump and RAM-command signals around ram_seq_ctrl.
// The controller uses the slave view and its environment uses the master view.
interface ram_seq_ctrl_if;
    logic         ld_valid;
    logic [127:0] ld_data;
    logic         ld_ready;
    logic         dump_req;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic [1:0]   ram_rw;
    logic [7:0]   ram_addr;
    logic [127:0] ram_wdata;
    logic [7:0]   ram_rdata;

    modport slave (
        input  ld_valid, ld_data, dump_req, out_ready, ram_rdata,
        output ld_ready, out_valid, out_data, out_last, busy, ram_rw, ram_addr, ram_wdata
    );

    modport master (
        output ld_valid, ld_data, dump_req, out_ready, ram_rdata,
        input  ld_ready, out_valid, out_data, out_last, busy, ram_rw, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_seq_ctrl.sv
// Sequencer that writes 128-bit blocks into a byte RAM and streams the first
// NBYTES bytes back out on request, arbitrating fairly between the two.
module ram_seq_ctrl #(
    parameter int NBYTES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RD    = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX   = 4'(NBYTES - 1);
    localparam logic [1:0] RW_LOCK    = 2'd0;
    localparam logic [1:0] RW_READ    = 2'd1;
    localparam logic [1:0] RW_WRITE   = 2'd2;
    localparam logic       GRANT_LOAD = 1'b0;
    localparam logic       GRANT_DUMP = 1'b1;

    state_t       state_r;
    state_t       state_nx_s;
    logic [3:0]   idx_r;
    logic [3:0]   idx_nx_s;
    logic [127:0] wdata_r;
    logic         dump_pend_r;
    logic         dump_pend_nx_s;
    logic         last_grant_r;
    logic         last_grant_nx_s;
    logic         pend_any_s;
    logic         load_grant_s;
    logic         dump_grant_s;
    logic [1:0]   rw_r;
    logic [1:0]   rw_nx_s;
    logic [7:0]   addr_r;
    logic         out_valid_r;
    logic         out_last_r;
    logic         out_last_nx_s;
    logic         busy_r;

    // Arbitration between a waiting load and a pending dump; a same-cycle pulse counts as pending
    always_comb begin
        pend_any_s      = dump_pend_r | bus.dump_req;
        load_grant_s    = 1'b0;
        dump_grant_s    = 1'b0;
        last_grant_nx_s = last_grant_r;
        if (state_r == IDLE) begin
            if (bus.ld_valid && pend_any_s) begin
                if (last_grant_r == GRANT_DUMP) begin
                    load_grant_s = 1'b1;
                end else begin
                    dump_grant_s = 1'b1;
                end
                last_grant_nx_s = ~last_grant_r;
            end else if (bus.ld_valid) begin
                load_grant_s = 1'b1;
            end else if (pend_any_s) begin
                dump_grant_s = 1'b1;
            end else begin
                load_grant_s = 1'b0;
            end
        end else begin
            load_grant_s = 1'b0;
        end
        dump_pend_nx_s = pend_any_s & ~dump_grant_s;
    end

    // Next-state and byte index sequencing
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (load_grant_s) begin
                    state_nx_s = WRITE;
                end else if (dump_grant_s) begin
                    state_nx_s = RD;
                    idx_nx_s   = 4'd0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WRITE: state_nx_s = IDLE;
            RD:    state_nx_s = WAIT;
            WAIT: begin
                if (bus.out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nx_s = IDLE;
                    end else begin
                        idx_nx_s   = idx_r + 4'd1;
                        state_nx_s = RD;
                    end
                end else begin
                    state_nx_s = WAIT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so they leave a register
    always_comb begin
        case (state_nx_s)
            WRITE:   rw_nx_s = RW_WRITE;
            RD:      rw_nx_s = RW_READ;
            default: rw_nx_s = RW_LOCK;
        endcase
        out_last_nx_s = (state_nx_s == WAIT) && (idx_nx_s == LAST_IDX);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= 4'd0;
            wdata_r      <= 128'd0;
            dump_pend_r  <= 1'b0;
            last_grant_r <= GRANT_DUMP;
            rw_r         <= RW_LOCK;
            addr_r       <= 8'd0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            idx_r        <= idx_nx_s;
            dump_pend_r  <= dump_pend_nx_s;
            last_grant_r <= last_grant_nx_s;
            if (load_grant_s) begin
                wdata_r <= bus.ld_data;
            end
            rw_r         <= rw_nx_s;
            addr_r       <= {4'h0, idx_nx_s};
            out_valid_r  <= (state_nx_s == WAIT);
            out_last_r   <= out_last_nx_s;
            busy_r       <= (state_nx_s != IDLE);
        end
    end

    // RAM keeps rdata under Lock, so the WAIT byte is passed straight through
    assign bus.ld_ready  = rst_n & (state_r == IDLE) & ~dump_grant_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_valid_r ? bus.ram_rdata : 8'h00;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;
    assign bus.ram_rw    = rw_r;
    assign bus.ram_addr  = addr_r;
    assign bus.ram_wdata = wdata_r;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Randomised and directed bench for ram_seq_ctrl: RAM model, load/dump scoreboard,
// request-coverage bookkeeping, and a second NBYTES=4 instance.
module tb_ram_seq_ctrl;

    localparam int NB  = 16;
    localparam int NB2 = 4;
    localparam logic [127:0] BLK0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK1 = 128'hA5A4A3A2A1A0B9B8B7B6B5B4B3B2B1B0;
    localparam logic [127:0] BLK2 = 128'h123456789ABCDEF00FEDCBA987654321;
    localparam logic [127:0] BLK3 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFC3B2A190;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_seq_ctrl_if bus ();
    ram_seq_ctrl_if bus2 ();

    ram_seq_ctrl #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    ram_seq_ctrl #(.NBYTES(NB2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] mem [16];
    logic [7:0] mem2 [16];

    // Byte RAMs: Write stores a whole block, Read returns one byte next edge, Lock holds rdata
    always @(posedge clk) begin
        if (bus.ram_rw == 2'd2) begin
            for (int i = 0; i < 16; i++) mem[i] <= bus.ram_wdata[i*8 +: 8];
        end else if (bus.ram_rw == 2'd1) begin
            bus.ram_rdata <= mem[bus.ram_addr[3:0]];
        end
        if (bus2.ram_rw == 2'd2) begin
            for (int i = 0; i < 16; i++) mem2[i] <= bus2.ram_wdata[i*8 +: 8];
        end else if (bus2.ram_rw == 2'd1) begin
            bus2.ram_rdata <= mem2[bus2.ram_addr[3:0]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard state: RAM contents implied by accepted loads, and unserved dump pulses
    logic [127:0] blk_ref = 128'd0;
    logic [127:0] exp_blk = 128'd0;
    int byte_cnt = 0;
    bit in_dump = 1'b0;
    int loads = 0;
    int writes = 0;
    int dumps = 0;
    int pulse_q[$];
    int grant_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_dump  = 1'b0;
                byte_cnt = 0;
                pulse_q.delete();
            end else begin
                check_eq("rw_legal", 128'(bus.ram_rw == 2'd3), 128'(0));
                check_eq("addr_hi", 128'(bus.ram_addr[7:4]), 128'(0));
                if (bus.busy) check_eq("ld_ready_busy", 128'(bus.ld_ready), 128'(0));
                if (!bus.out_valid) check_eq("last_no_valid", 128'(bus.out_last), 128'(0));
                if (bus.ld_valid && bus.ld_ready) begin
                    blk_ref = bus.ld_data;
                    loads++;
                end
                if (bus.ram_rw == 2'd2) begin
                    check_eq("wdata", bus.ram_wdata, blk_ref);
                    writes++;
                    grant_log.push_back(0);
                end
                if (bus.ram_rw == 2'd1) begin
                    if (!in_dump) begin
                        in_dump  = 1'b1;
                        byte_cnt = 0;
                        exp_blk  = blk_ref;
                        dumps++;
                        grant_log.push_back(1);
                        check_eq("dump_has_req", 128'(pulse_q.size() > 0 && pulse_q[0] <= cyc), 128'(1));
                        while (pulse_q.size() > 0 && pulse_q[0] <= cyc) void'(pulse_q.pop_front());
                    end
                    check_eq("rd_addr", 128'(bus.ram_addr), 128'(byte_cnt));
                    check_eq("rd_no_valid", 128'(bus.out_valid), 128'(0));
                end
                if (bus.out_valid) begin
                    check_eq("wait_lock", 128'(bus.ram_rw), 128'(0));
                    check_eq("out_data", 128'(bus.out_data), 128'(exp_blk[byte_cnt*8 +: 8]));
                    check_eq("out_last", 128'(bus.out_last), 128'(byte_cnt == NB - 1));
                    if (bus.out_ready) begin
                        byte_cnt++;
                        if (byte_cnt == NB) in_dump = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_dump();
        bus.dump_req = 1'b1;
        pulse_q.push_back(cyc + 1);
        tick();
        bus.dump_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (!bus.busy && pulse_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check_eq("idle_timeout", 128'(0), 128'(1));
    endtask

    task automatic do_load(input logic [127:0] d);
        int l0 = loads;
        bus.ld_data  = d;
        bus.ld_valid = 1'b1;
        for (int t = 0; t < 100 && loads == l0; t++) tick();
        bus.ld_valid = 1'b0;
        check_eq("load_accepted", 128'(loads - l0), 128'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int first_v;
        int stall;
        int w0;
        int d0;
        int l0;
        int gl0;
        int rd_n;
        int by_n;
        logic [127:0] blk4;

        bus.ld_valid = 1'b0;  bus.ld_data = 128'd0;  bus.dump_req = 1'b0;  bus.out_ready = 1'b1;
        bus2.ld_valid = 1'b0; bus2.ld_data = 128'd0; bus2.dump_req = 1'b0; bus2.out_ready = 1'b1;

        // Reset values while rst_n is held low
        tick();
        tick();
        check_eq("rst_rw", 128'(bus.ram_rw), 128'(0));
        check_eq("rst_addr", 128'(bus.ram_addr), 128'(0));
        check_eq("rst_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_last", 128'(bus.out_last), 128'(0));
        check_eq("rst_busy", 128'(bus.busy), 128'(0));
        check_eq("rst_ld_ready", 128'(bus.ld_ready), 128'(0));
        check_eq("rst_wdata", bus.ram_wdata, 128'(0));
        rst_n = 1'b1;
        #1;
        check_eq("ld_ready_after_rst", 128'(bus.ld_ready), 128'(1));
        tick();

        // Single load then full dump at full throughput
        w0 = writes;
        do_load(BLK0);
        wait_idle(20);
        tick();
        check_eq("one_write", 128'(writes - w0), 128'(1));
        d0 = dumps;
        pulse_dump();
        n = 0;
        first_v = -1;
        for (int t = 0; t < 100; t++) begin
            if (!bus.busy) break;
            if (bus.out_valid && first_v < 0) first_v = n;
            n++;
            tick();
        end
        check_eq("dump_cycles", 128'(n), 128'(32));
        check_eq("first_valid_lat", 128'(first_v), 128'(1));
        wait_idle(20);
        check_eq("one_dump", 128'(dumps - d0), 128'(1));

        // Downstream stall on byte 3
        stall = 0;
        pulse_dump();
        for (int t = 0; t < 300 && (bus.busy || pulse_q.size() > 0); t++) begin
            if (bus.out_valid && byte_cnt == 3 && stall < 5) begin
                check_eq("stall_data", 128'(bus.out_data), 128'(8'h03));
                check_eq("stall_lock", 128'(bus.ram_rw), 128'(0));
                stall++;
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = 1'b1;
            end
            tick();
        end
        bus.out_ready = 1'b1;
        check_eq("stall_cycles", 128'(stall), 128'(5));
        wait_idle(20);

        // Two pulses during a dump collapse into one extra dump
        d0 = dumps;
        pulse_dump();
        repeat (3) tick();
        pulse_dump();
        repeat (4) tick();
        pulse_dump();
        wait_idle(200);
        check_eq("collapse_dumps", 128'(dumps - d0), 128'(2));

        // Tie arbitration: after reset load wins first, then dump wins the next tie
        do_reset();
        for (int k = 0; k < 2; k++) begin
            gl0 = grant_log.size();
            l0  = loads;
            bus.ld_data  = (k == 0) ? BLK1 : BLK2;
            bus.ld_valid = 1'b1;
            bus.dump_req = 1'b1;
            pulse_q.push_back(cyc + 1);
            tick();
            bus.dump_req = 1'b0;
            for (int t = 0; t < 100 && loads == l0; t++) tick();
            bus.ld_valid = 1'b0;
            wait_idle(100);
            tick();
            check_eq("tie_count", 128'(grant_log.size() - gl0), 128'(2));
            check_eq("tie_first", 128'(grant_log[gl0]), 128'(k));
            check_eq("tie_second", 128'(grant_log[gl0 + 1]), 128'(1 - k));
        end

        // Reset in WAIT of byte 7 aborts the dump; RAM keeps its contents
        w0 = writes;
        pulse_dump();
        for (int t = 0; t < 200 && !(bus.out_valid && byte_cnt == 7); t++) tick();
        check_eq("reached_byte7", 128'(bus.out_valid && byte_cnt == 7), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 128'(bus.out_valid), 128'(0));
        check_eq("abort_rw", 128'(bus.ram_rw), 128'(0));
        check_eq("abort_busy", 128'(bus.busy), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("abort_no_write", 128'(writes - w0), 128'(0));
        d0 = dumps;
        pulse_dump();
        wait_idle(100);
        check_eq("post_rst_dump", 128'(dumps - d0), 128'(1));

        // Random traffic against the scoreboard
        for (int t = 0; t < 1500; t++) begin
            bus.ld_valid  = ($urandom_range(0, 5) == 0);
            bus.ld_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.dump_req && $urandom_range(0, 15) == 0) begin
                bus.dump_req = 1'b1;
                pulse_q.push_back(cyc + 1);
            end else begin
                bus.dump_req = 1'b0;
            end
            tick();
        end
        bus.ld_valid  = 1'b0;
        bus.dump_req  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle(2000);
        check_eq("all_req_served", 128'(pulse_q.size()), 128'(0));

        // NBYTES=4 instance: only addresses 0..3, last on byte 3
        blk4 = BLK3;
        bus2.ld_data  = blk4;
        bus2.ld_valid = 1'b1;
        tick();
        bus2.ld_valid = 1'b0;
        tick();
        tick();
        bus2.dump_req = 1'b1;
        tick();
        bus2.dump_req = 1'b0;
        rd_n = 0;
        by_n = 0;
        for (int t = 0; t < 40; t++) begin
            if (bus2.ram_rw == 2'd1) begin
                check_eq("nb4_addr", 128'(bus2.ram_addr), 128'(rd_n));
                rd_n++;
            end
            if (bus2.out_valid) begin
                check_eq("nb4_data", 128'(bus2.out_data), 128'(blk4[by_n*8 +: 8]));
                check_eq("nb4_last", 128'(bus2.out_last), 128'(by_n == NB2 - 1));
                by_n++;
            end
            tick();
        end
        check_eq("nb4_reads", 128'(rd_n), 128'(NB2));
        check_eq("nb4_bytes", 128'(by_n), 128'(NB2));
        check_eq("nb4_idle", 128'(bus2.busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
